// File: rtl/aftab_seq_tcl_pkg.sv
// aftab_seq_tcl_pkg: shared modes, FSM states and slice-geometry helpers
package aftab_seq_tcl_pkg;
  localparam logic [1:0] TCL_PASS = 2'b00;
  localparam logic [1:0] TCL_NEG = 2'b01;
  localparam logic [1:0] TCL_ABS = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int nsl(input int size, input int slice);
    return (size + slice - 1) / slice;
  endfunction
  function automatic int last_w(input int size, input int slice);
    return size - (nsl(size, slice) - 1) * slice;
  endfunction
endpackage

// File: rtl/aftab_seq_tcl_if.sv
// aftab_seq_tcl_if: start/done handshake and operand/result bundle
interface aftab_seq_tcl_if #(parameter int SIZE = 33);
  logic start;
  logic abort;
  logic [1:0] mode;
  logic [SIZE-1:0] operand;
  logic [SIZE-1:0] result;
  logic busy;
  logic done;
  logic sign_out;
  logic overflow;
  modport master(output start, abort, mode, operand, input result, busy, done, sign_out, overflow);
  modport slave(input start, abort, mode, operand, output result, busy, done, sign_out, overflow);
endinterface

// File: rtl/aftab_seq_tcl_slice.sv
// aftab_tcl_slice: one slice of a conditional invert-and-increment
module aftab_tcl_slice #(parameter int W = 8) (
  input  logic [W-1:0] in,
  input  logic         inv,
  input  logic         cin,
  output logic [W-1:0] out,
  output logic         cout
);
  assign {cout, out} = {1'b0, inv ? ~in : in} + (W+1)'(cin);
endmodule

// File: rtl/aftab_seq_tcl.sv
// aftab_seq_tcl: sliced multi-cycle pass/negate/abs two's-complement unit
module aftab_seq_tcl
  import aftab_seq_tcl_pkg::*;
#(
  parameter int SIZE = 33,
  parameter int SLICE = 8
) (
  input logic clk,
  input logic rst_n,
  aftab_seq_tcl_if.slave bus
);
  localparam int NSL = nsl(SIZE, SLICE);
  localparam int LW = last_w(SIZE, SLICE);
  localparam int PW = NSL * SLICE;
  localparam int CW = NSL > 1 ? $clog2(NSL) : 1;
  localparam logic [SIZE-1:0] MOST_NEG = {1'b1, {(SIZE-1){1'b0}}};
  state_t state, state_d;
  logic [SIZE-1:0] op, result;
  logic [CW-1:0] cnt;
  logic carry, sign_out, overflow, accept, last, neg_in, cout;
  logic [SLICE-1:0] op_slice, sum, mask;
  logic [PW-1:0] op_pad, res_pad;
  int sh;
  aftab_tcl_slice #(.W(SLICE)) u_slice (
    .in(op_slice),
    .inv(sign_out),
    .cin(carry),
    .out(sum),
    .cout(cout)
  );
  // select the current slice and merge its sum into the result; the last slice is masked to its real width
  always_comb begin
    accept = state != RUN && bus.start;
    last = cnt == CW'(NSL - 1);
    neg_in = bus.mode == TCL_NEG || (bus.mode == TCL_ABS && bus.operand[SIZE-1]);
    sh = int'(cnt) * SLICE;
    op_pad = PW'(op);
    op_slice = SLICE'(op_pad >> sh);
    mask = last ? SLICE'({LW{1'b1}}) : '1;
    res_pad = PW'(result);
    res_pad = (res_pad & ~(PW'(mask) << sh)) | (PW'(sum & mask) << sh);
  end
  // next state: abort beats completion on the last slice
  always_comb begin
    state_d = state == RUN ? (bus.abort ? IDLE : last ? DONE : RUN) : (bus.start ? RUN : IDLE);
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  // capture on start, then ripple one slice per clock through the carry register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op <= '0;
      result <= '0;
      cnt <= '0;
      carry <= 1'b0;
      sign_out <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      op <= bus.operand;
      carry <= neg_in;
      cnt <= '0;
      sign_out <= neg_in;
      overflow <= neg_in && bus.operand == MOST_NEG;
    end else if (state == RUN && !bus.abort) begin
      result <= SIZE'(res_pad);
      carry <= cout;
      cnt <= cnt + 1'b1;
    end
  end
  assign bus.result = result;
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sign_out = sign_out;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_aftab_seq_tcl.sv
// tb_aftab_seq_tcl: scoreboard bench for the sliced two's-complement unit
module tb_aftab_seq_tcl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  typedef struct {
    logic [32:0] res;
    logic sgn;
    logic ovf;
    int due;
  } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  aftab_seq_tcl_if #(.SIZE(33)) a_if ();
  aftab_seq_tcl_if #(.SIZE(32)) b_if ();
  aftab_seq_tcl_if #(.SIZE(33)) c_if ();
  aftab_seq_tcl #(.SIZE(33), .SLICE(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_if.slave));
  aftab_seq_tcl #(.SIZE(32), .SLICE(32)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_if.slave));
  aftab_seq_tcl #(.SIZE(33), .SLICE(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(c_if.slave));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // monitor: every done pulse of the 33/8 unit must match the oldest expectation, on time
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && a_if.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected done: result %0h with no pending operation", a_if.result);
      end else begin
        e = sb.pop_front();
        chk("result", 64'(a_if.result), 64'(e.res));
        chk("sign_out", 64'(a_if.sign_out), 64'(e.sgn));
        chk("overflow", 64'(a_if.overflow), 64'(e.ovf));
        chk("done cycle", 64'(cyc), 64'(e.due));
      end
    end
  end
  task automatic op_a(input logic [1:0] m, input logic [32:0] v, input logic [32:0] r, input logic s, input logic o);
    @(negedge clk);
    a_if.mode = m;
    a_if.operand = v;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    sb.push_back('{r, s, o, cyc + 5});
  endtask
  task automatic drain;
    for (int i = 0; i < 200 && (sb.size() != 0 || a_if.busy); i++) @(negedge clk);
    chk("drain pending", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask
  initial begin
    int n;
    {a_if.start, a_if.abort, a_if.mode, a_if.operand} = '0;
    {b_if.start, b_if.abort, b_if.mode, b_if.operand} = '0;
    {c_if.start, c_if.abort, c_if.mode, c_if.operand} = '0;
    repeat (2) @(negedge clk);
    chk("reset result", 64'(a_if.result), 64'd0);
    chk("reset busy", 64'(a_if.busy), 64'd0);
    chk("reset done", 64'(a_if.done), 64'd0);
    chk("reset sign", 64'(a_if.sign_out), 64'd0);
    chk("reset ovf", 64'(a_if.overflow), 64'd0);
    rst_n = 1'b1;
    op_a(2'b01, 33'h0_0000_0005, 33'h1_FFFF_FFFB, 1'b1, 1'b0);
    n = 0;
    while (a_if.busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy cycles", 64'(n), 64'd5);
    drain();
    op_a(2'b10, 33'h1_FFFF_FFFB, 33'h0_0000_0005, 1'b1, 1'b0);
    drain();
    op_a(2'b10, 33'h0_0000_0005, 33'h0_0000_0005, 1'b0, 1'b0);
    drain();
    op_a(2'b01, 33'h1_0000_0000, 33'h1_0000_0000, 1'b1, 1'b1);
    drain();
    op_a(2'b01, 33'h0, 33'h0, 1'b1, 1'b0);
    drain();
    op_a(2'b00, 33'h1_2345_6789, 33'h1_2345_6789, 1'b0, 1'b0);
    drain();
    op_a(2'b11, 33'h1_ABCD_EF01, 33'h1_ABCD_EF01, 1'b0, 1'b0);
    drain();
    op_a(2'b01, 33'd7, 33'h1_FFFF_FFF9, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    op_a(2'b01, 33'd9, 33'h1_FFFF_FFF7, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    a_if.mode = 2'b00;
    a_if.operand = 33'h1_1111_1111;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    a_if.mode = 2'b01;
    a_if.operand = 33'd3;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst result", 64'(a_if.result), 64'd0);
    chk("async rst busy", 64'(a_if.busy), 64'd0);
    chk("async rst done", 64'(a_if.done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    a_if.operand = 33'd11;
    a_if.start = 1'b1;
    @(negedge clk);
    a_if.start = 1'b0;
    repeat (3) @(negedge clk);
    a_if.abort = 1'b1;
    @(negedge clk);
    a_if.abort = 1'b0;
    chk("abort busy", 64'(a_if.busy), 64'd0);
    repeat (8) @(negedge clk);
    op_a(2'b01, 33'd5, 33'h1_FFFF_FFFB, 1'b1, 1'b0);
    drain();
    b_if.mode = 2'b01;
    b_if.operand = 32'h0000_0001;
    b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    chk("w32 busy", 64'(b_if.busy), 64'd1);
    @(negedge clk);
    chk("w32 done", 64'(b_if.done), 64'd1);
    chk("w32 result", 64'(b_if.result), 64'hFFFF_FFFF);
    c_if.mode = 2'b01;
    c_if.operand = 33'd5;
    c_if.start = 1'b1;
    @(negedge clk);
    c_if.start = 1'b0;
    n = 0;
    while (c_if.busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("s1 busy cycles", 64'(n), 64'd33);
    chk("s1 done", 64'(c_if.done), 64'd1);
    chk("s1 result", 64'(c_if.result), 64'h1_FFFF_FFFB);
    chk("s1 sign", 64'(c_if.sign_out), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
